// File: rtl/jtag_link_fifo.sv
// USB-JTAG pin link: synchronised TCK/TCS/TDI deserialised into an RX FIFO,
// TX FIFO words serialised onto TDO, full duplex, one word per DATA_W TCK cycles.
module jtag_link_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                        CLOCK_50,
  input  logic                        RST_N,
  input  logic                        TCK,
  input  logic                        TCS,
  input  logic                        TDI,
  output logic                        TDO,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        rx_overflow,
  output logic                        tx_underrun,
  input  logic                        clr_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state_reg, state_next;

  logic tck_s1, tck_s2, tck_s3, tcs_s1, tcs_s2, tdi_s1, tdi_s2;
  logic [1:0] prime_reg;
  logic tck_rise, tck_fall, primed;

  logic [DATA_W-1:0] rx_shift_reg, tx_shift_reg, rx_word, tx_shifted, tx_head;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              word_done_reg, word_last;
  logic              start, rx_step, tx_load, tx_step;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic rx_full, rx_pop, rx_push, rx_accept, rx_drop;
  logic tx_wr, tx_empty, tx_pop, underrun_evt;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      {tck_s1, tck_s2, tck_s3} <= 3'b000;
      {tcs_s1, tcs_s2}         <= 2'b00;
      {tdi_s1, tdi_s2}         <= 2'b00;
      prime_reg                <= 2'b00;
    end else begin
      {tck_s1, tck_s2, tck_s3} <= {TCK, tck_s1, tck_s2};
      {tcs_s1, tcs_s2}         <= {TCS, tcs_s1};
      {tdi_s1, tdi_s2}         <= {TDI, tdi_s1};
      prime_reg                <= {prime_reg[0], 1'b1};
    end
  end

  // Synchronisers reset to 0, so tcs_s2 only reflects the pin once refilled;
  // without this a frame held across reset would look like a fresh TCS low.
  assign primed   = prime_reg[1];
  assign tck_rise = tck_s2 & ~tck_s3;
  assign tck_fall = ~tck_s2 & tck_s3;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) state_reg <= WAIT_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    rx_step    = 1'b0;
    tx_load    = 1'b0;
    tx_step    = 1'b0;
    case (state_reg)
      WAIT_IDLE: if (primed && !tcs_s2) state_next = IDLE;
      IDLE: if (tcs_s2) begin
        start      = 1'b1;
        tx_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (!tcs_s2) state_next = IDLE;
        else begin
          rx_step = tck_rise;
          tx_load = tck_fall & word_done_reg;
          tx_step = tck_fall & ~word_done_reg;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  generate
    if (LSB_FIRST) begin : g_lsb
      assign rx_word    = {tdi_s2, rx_shift_reg[DATA_W-1:1]};
      assign tx_shifted = {1'b0, tx_shift_reg[DATA_W-1:1]};
      assign TDO        = tx_shift_reg[0];
    end else begin : g_msb
      assign rx_word    = {rx_shift_reg[DATA_W-2:0], tdi_s2};
      assign tx_shifted = {tx_shift_reg[DATA_W-2:0], 1'b0};
      assign TDO        = tx_shift_reg[DATA_W-1];
    end
  endgenerate

  assign word_last    = (bit_cnt_reg == CNT_W'(DATA_W - 1));
  assign rx_push      = rx_step & word_last;
  assign rx_full      = (rx_level == LVL_W'(FIFO_DEPTH));
  assign rx_valid     = (rx_level != '0);
  assign rx_pop       = rx_valid & rx_ready;
  assign rx_accept    = rx_push & (~rx_full | rx_pop);
  assign rx_drop      = rx_push & rx_full & ~rx_pop;
  assign rx_data      = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  assign tx_ready     = (tx_level != LVL_W'(FIFO_DEPTH));
  assign tx_wr        = tx_valid & tx_ready;
  assign tx_empty     = (tx_level == '0);
  assign tx_pop       = tx_load & ~tx_empty;
  assign underrun_evt = tx_load & tx_empty;
  assign tx_head      = tx_mem[tx_rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (rx_accept) rx_mem[rx_wr_ptr] <= rx_word;
    if (tx_wr)     tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      word_done_reg <= 1'b0;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      tx_wr_ptr     <= '0;
      tx_rd_ptr     <= '0;
      rx_level      <= '0;
      tx_level      <= '0;
      rx_overflow   <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt_reg   <= '0;
        word_done_reg <= 1'b0;
      end
      if (rx_step) begin
        rx_shift_reg  <= rx_word;
        bit_cnt_reg   <= word_last ? '0 : bit_cnt_reg + CNT_W'(1);
        word_done_reg <= word_last;
      end
      if (tx_load)      tx_shift_reg <= tx_pop ? tx_head : '0;
      else if (tx_step) tx_shift_reg <= tx_shifted;
      if (tck_fall && state_reg == SHIFT) word_done_reg <= 1'b0;

      if (rx_accept) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      if (tx_wr)     tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)    tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      rx_level <= rx_level + LVL_W'(rx_accept) - LVL_W'(rx_pop);
      tx_level <= tx_level + LVL_W'(tx_wr) - LVL_W'(tx_pop);

      // A new event in the same cycle as clr_flags keeps the flag set.
      rx_overflow <= rx_drop | (rx_overflow & ~clr_flags);
      tx_underrun <= underrun_evt | (tx_underrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_jtag_link_fifo.sv
// Directed bench for jtag_link_fifo: an 8-bit LSB-first instance and a
// 12-bit MSB-first instance share the host pins; the host is modelled bit by bit.
module tb_jtag_link_fifo;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, tck, tcs, tdi, clr_flags;

  logic        tdo_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, ovf_a, und_a;
  logic [7:0]  tx_data_a, rx_data_a;
  logic [2:0]  rx_level_a, tx_level_a;

  logic        tdo_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, ovf_b, und_b;
  logic [11:0] tx_data_b, rx_data_b;
  logic [2:0]  rx_level_b, tx_level_b;

  jtag_link_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1)) dut_a (
    .CLOCK_50(clk), .RST_N(rst_n), .TCK(tck), .TCS(tcs), .TDI(tdi), .TDO(tdo_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_level(rx_level_a), .tx_level(tx_level_a),
    .rx_overflow(ovf_a), .tx_underrun(und_a), .clr_flags(clr_flags));

  jtag_link_fifo #(.DATA_W(12), .FIFO_DEPTH(4), .LSB_FIRST(1'b0)) dut_b (
    .CLOCK_50(clk), .RST_N(rst_n), .TCK(tck), .TCS(tcs), .TDI(tdi), .TDO(tdo_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_level(rx_level_b), .tx_level(tx_level_b),
    .rx_overflow(ovf_b), .tx_underrun(und_b), .clr_flags(clr_flags));

  typedef struct {
    bit          sel;
    logic [31:0] tdi_w;
    logic [31:0] tx_w;
    logic [31:0] exp_rx;
    logic [31:0] exp_tdo;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] tdi_words[8];
  logic [31:0] tdo_words[8];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] g_rx_data(input bit s);
    return s ? 32'(rx_data_b) : 32'(rx_data_a);
  endfunction
  function automatic logic [31:0] g_rx_valid(input bit s);
    return s ? 32'(rx_valid_b) : 32'(rx_valid_a);
  endfunction
  function automatic logic [31:0] g_tx_level(input bit s);
    return s ? 32'(tx_level_b) : 32'(tx_level_a);
  endfunction
  function automatic logic [31:0] g_underrun(input bit s);
    return s ? 32'(und_b) : 32'(und_a);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic push_tx(input bit s, input logic [31:0] w);
    @(negedge clk);
    if (s) begin tx_valid_b = 1'b1; tx_data_b = w[11:0]; end
    else   begin tx_valid_a = 1'b1; tx_data_a = w[7:0]; end
    @(negedge clk);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  task automatic pop_rx(input bit s);
    @(negedge clk);
    if (s) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // One TCK period; TDO is captured at the rising edge. On the last bit TCS
  // drops while TCK is still high so no trailing TX load happens.
  task automatic send_bit(input bit s, input logic b, input bit last, output logic t);
    tdi = b;
    wait_cyc(6);
    tck = 1'b1;
    t = s ? tdo_b : tdo_a;
    wait_cyc(6);
    if (last) begin
      tcs = 1'b0;
      wait_cyc(6);
    end
    tck = 1'b0;
    wait_cyc(6);
  endtask

  task automatic run_frame(input bit s, input int nw, input int abort_bits);
    int dw, total, w, bi;
    logic t;
    dw    = s ? 12 : 8;
    total = nw * dw;
    for (int k = 0; k < 8; k++) tdo_words[k] = '0;
    tcs = 1'b1;
    for (int k = 0; k < total; k++) begin
      if (abort_bits > 0 && k == abort_bits) break;
      w  = k / dw;
      bi = s ? (dw - 1 - (k % dw)) : (k % dw);
      send_bit(s, tdi_words[w][bi], (k == total - 1), t);
      tdo_words[w][bi] = t;
    end
    if (abort_bits > 0) begin
      tcs = 1'b0;
      wait_cyc(8);
    end
  endtask

  initial begin
    logic t;
    vecs[0] = '{1'b0, 32'h0A5, 32'h03C, 32'h0A5, 32'h03C};
    vecs[1] = '{1'b0, 32'h05A, 32'h0C3, 32'h05A, 32'h0C3};
    vecs[2] = '{1'b0, 32'h081, 32'h07E, 32'h081, 32'h07E};
    vecs[3] = '{1'b0, 32'h000, 32'h0FF, 32'h000, 32'h0FF};
    vecs[4] = '{1'b1, 32'hABC, 32'h123, 32'hABC, 32'h123};
    vecs[5] = '{1'b1, 32'h801, 32'hF0E, 32'h801, 32'hF0E};

    rst_n = 1'b0; tck = 1'b0; tcs = 1'b0; tdi = 1'b0; clr_flags = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = '0; rx_ready_a = 1'b0;
    tx_valid_b = 1'b0; tx_data_b = '0; rx_ready_b = 1'b0;
    wait_cyc(3);

    chk("reset_tdo",      32'(tdo_a), 0);
    chk("reset_rx_valid", 32'(rx_valid_a), 0);
    chk("reset_rx_data",  32'(rx_data_a), 0);
    chk("reset_tx_ready", 32'(tx_ready_a), 1);
    chk("reset_rx_level", 32'(rx_level_a), 0);
    chk("reset_tx_level", 32'(tx_level_a), 0);
    chk("reset_overflow", 32'(ovf_a), 0);
    chk("reset_underrun", 32'(und_a), 0);
    rst_n = 1'b1;
    wait_cyc(4);

    for (int v = 0; v < 6; v++) begin
      if (v == 0 || vecs[v].sel != vecs[v-1].sel) do_reset();
      push_tx(vecs[v].sel, vecs[v].tx_w);
      chk($sformatf("v%0d_tx_level_pre", v), g_tx_level(vecs[v].sel), 1);
      tdi_words[0] = vecs[v].tdi_w;
      run_frame(vecs[v].sel, 1, 0);
      chk($sformatf("v%0d_rx_valid", v), g_rx_valid(vecs[v].sel), 1);
      chk($sformatf("v%0d_rx_data", v), g_rx_data(vecs[v].sel), vecs[v].exp_rx);
      chk($sformatf("v%0d_tdo_word", v), tdo_words[0], vecs[v].exp_tdo);
      chk($sformatf("v%0d_tx_level_post", v), g_tx_level(vecs[v].sel), 0);
      chk($sformatf("v%0d_underrun", v), g_underrun(vecs[v].sel), 0);
      pop_rx(vecs[v].sel);
      chk($sformatf("v%0d_rx_valid_popped", v), g_rx_valid(vecs[v].sel), 0);
    end

    // Back-to-back 3-word frame with the TX FIFO empty.
    do_reset();
    tdi_words[0] = 32'h11; tdi_words[1] = 32'h22; tdi_words[2] = 32'h33;
    run_frame(1'b0, 3, 0);
    chk("b2b_rx_level", 32'(rx_level_a), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("b2b_tdo%0d", k), tdo_words[k], 0);
    chk("b2b_underrun", 32'(und_a), 1);
    chk("b2b_overflow", 32'(ovf_a), 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_rx%0d", k), 32'(rx_data_a), tdi_words[k]);
      pop_rx(1'b0);
    end
    clear_flags();
    chk("b2b_underrun_cleared", 32'(und_a), 0);

    // Five words into a 4-deep RX FIFO with no reader.
    for (int k = 0; k < 5; k++) tdi_words[k] = 32'(k + 1);
    run_frame(1'b0, 5, 0);
    chk("full_rx_level", 32'(rx_level_a), 4);
    chk("full_overflow", 32'(ovf_a), 1);
    chk("full_tx_ready", 32'(tx_ready_a), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_rx%0d", k), 32'(rx_data_a), 32'(k + 1));
      pop_rx(1'b0);
    end
    chk("full_drained", 32'(rx_valid_a), 0);
    clear_flags();
    chk("full_overflow_cleared", 32'(ovf_a), 0);
    chk("full_underrun_cleared", 32'(und_a), 0);

    // Frame aborted after 5 bits, then a clean frame.
    tdi_words[0] = 32'hFF;
    run_frame(1'b0, 1, 5);
    chk("abort_rx_level", 32'(rx_level_a), 0);
    tdi_words[0] = 32'h81;
    run_frame(1'b0, 1, 0);
    chk("abort_next_level", 32'(rx_level_a), 1);
    chk("abort_next_data", 32'(rx_data_a), 32'h81);
    pop_rx(1'b0);
    clear_flags();

    // Reset pulsed mid-frame with TCS held high.
    tcs = 1'b1;
    for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b1, 1'b0, t);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("midrst_rx_level_in_reset", 32'(rx_level_a), 0);
    chk("midrst_tdo_in_reset", 32'(tdo_a), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) send_bit(1'b0, k[0], (k == 9), t);
    chk("midrst_no_push", 32'(rx_level_a), 0);
    chk("midrst_no_load", 32'(und_a), 0);
    tdi_words[0] = 32'h42;
    run_frame(1'b0, 1, 0);
    chk("midrst_next_level", 32'(rx_level_a), 1);
    chk("midrst_next_data", 32'(rx_data_a), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_link_fifo.md
# jtag_link_fifo

Parametrised, buffered successor to the fixed 8-bit USB-JTAG receiver/transmitter pair. It runs entirely in the CLOCK_50 domain: it synchronises the host-driven TCK/TCS/TDI pins, deserialises DATA_W-bit words into an RX FIFO and serialises words from a TX FIFO onto TDO. Words are full-duplex, one per DATA_W TCK cycles. It sits between the board's USB-JTAG pins and user logic, such as CNN weight/image loaders and result readback, through valid/ready streams.

## Interface
- DATA_W, 8: bits per word, 2..32.
- FIFO_DEPTH, 16: entries per FIFO; power of two, at least 2.
- LSB_FIRST, 1: 1 means bit 0 is shifted first in both directions; 0 means MSB first.
- LVL_W is derived as clog2(FIFO_DEPTH)+1.

Ports (clock and reset first):
- CLOCK_50  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous, active-low reset.
- TCK  in  1  host serial clock; asynchronous to CLOCK_50.
- TCS  in  1  host frame select, active high; asynchronous.
- TDI  in  1  host to FPGA data; asynchronous.
- TDO  out  1  FPGA to host data.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX FIFO not full; a write happens when tx_valid && tx_ready.
- rx_data  out  DATA_W  head of the RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop the RX FIFO when rx_valid && rx_ready.
- rx_level  out  LVL_W  RX FIFO occupancy.
- tx_level  out  LVL_W  TX FIFO occupancy.
- rx_overflow  out  1  sticky: a completed RX word was dropped because the RX FIFO was full.
- tx_underrun  out  1  sticky: a word slot was sent as zeros because the TX FIFO was empty.
- clr_flags  in  1  synchronous clear of both sticky flags.

## Operation
- TCK, TCS and TDI each pass through a 2-flop synchroniser. TCK gets a third flop to produce single-cycle pulses tck_rise and tck_fall.
- The FSM has three states:
  - WAIT_IDLE: the reset state. Moves to IDLE once synced TCS=0, so a frame already in progress at reset release is ignored.
  - IDLE: on synced TCS 0->1, load the TX word, clear bit_cnt, go to SHIFT.
  - SHIFT: synced TCS=0 returns to IDLE. The partial RX word is discarded. The partial TX word is lost; it was already popped.
- In SHIFT, on tck_rise: shift synced TDI into rx_shift and increment bit_cnt.
  - When bit_cnt reaches DATA_W-1, the word is complete. Push rx_shift (including this bit) into the RX FIFO and set bit_cnt to 0.
  - If the RX FIFO is full and not popped in the same cycle, drop the word and set rx_overflow.
- In SHIFT, on tck_fall: if the preceding tck_rise completed a word, load the next TX word; otherwise shift tx_shift and present the next bit on TDO.
- TX load: pop the TX FIFO head into tx_shift and drive its first bit on TDO. If the FIFO is empty, load all zeros and set tx_underrun.
- Bit order: LSB_FIRST=1 means bit i is the i-th bit on the wire; otherwise the MSB goes first. The same rule applies to RX.
- Both FIFOs are DATA_W x FIFO_DEPTH circular buffers. Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the level counter is LVL_W bits.
- Simultaneous events:
  - Push and pop on a full RX FIFO: the push is accepted and there is no overflow.
  - User write and TX load on an empty TX FIFO in the same cycle: the load sees empty and sends zeros; the write is accepted.
  - clr_flags and a new flag event in the same cycle: the flag is set (set wins).

## Timing
- Reset values: TDO=0, rx_valid=0, rx_data=0, tx_ready=1, rx_level=0, tx_level=0, rx_overflow=0, tx_underrun=0, FSM=WAIT_IDLE, all synchroniser flops 0.
- Pin-to-pulse latency is 3 CLOCK_50 cycles. TCK high and low phases must each be at least 4 CLOCK_50 cycles (TCK no faster than 6.25 MHz).
- RX: on the cycle after the completing tck_rise, rx_valid=1 and rx_data is valid (when the FIFO was empty).
- TX: TDO updates on the cycle after tck_fall, or after the TCS-rise detection for the first bit. The host samples TDO on TCK rising.
- tx_ready and rx_valid/levels update on the cycle after a write or pop. Throughput is 1 word/cycle on the user side.
- Reset asserted mid-frame clears all state immediately. After release, nothing happens until synced TCS has been seen low.

## Test plan
- DATA_W=8, LSB_FIRST=1: host shifts 0xA5 on TDI and the TX FIFO holds 0x3C. Required: rx_data=0xA5 with rx_valid; TDO bits 0,0,1,1,1,1,0,0; tx_level 1->0.
- Back-to-back frame of 3 words with the TX FIFO empty: 3 RX pushes, TDO all 0, tx_underrun=1. clr_flags clears it next cycle.
- RX full: FIFO_DEPTH=4, rx_ready=0, host sends 5 words. Required: rx_level=4, rx_overflow=1, the first 4 words are retained in order.
- TCS dropped after 5 bits, then a full frame of 0x81: exactly one RX word equal to 0x81 and no stale bits.
- RST_N pulsed mid-frame while TCS stays high: no RX push until TCS falls and rises again.
- DATA_W=12, LSB_FIRST=0: host sends 0xABC MSB first. Required: rx_data=0xABC, and TX 0x123 appears MSB first on TDO.
